// File: rtl/alu_exec_unit.sv
// ALU execution unit: single-cycle logic/arithmetic ops plus an iterative shift-add multiply,
// with registered result and flags behind valid/ready handshakes.
module alu_exec_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_ctrl,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             overflow,
    output logic             illegal_op
);

    typedef enum logic [1:0] {StIdle, StMul, StDone} state_e;

    localparam logic [CNT_W-1:0] CntLast = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             overflow_q, overflow_d;
    logic             illegal_q, illegal_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] sum, diff, op_res, acc_next;
    logic             op_ovf, op_ill, accept;

    assign in_ready   = (state_q == StIdle) && (!out_valid_q || out_ready);
    assign accept     = in_valid && in_ready;
    assign out_valid  = out_valid_q;
    assign result     = result_q;
    assign zero       = zero_q;
    assign overflow   = overflow_q;
    assign illegal_op = illegal_q;

    assign sum  = src_a + src_b;
    assign diff = src_a - src_b;

    always_comb begin
        op_res = '0;
        op_ovf = 1'b0;
        op_ill = 1'b0;
        case (alu_ctrl)
            3'b010: begin
                op_res = sum;
                op_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b110: begin
                op_res = diff;
                op_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (diff[WIDTH-1] != src_a[WIDTH-1]);
            end
            3'b000: op_res = src_a & src_b;
            3'b001: op_res = src_a | src_b;
            // Signed compare directly, so an overflowing A-B cannot flip the answer
            3'b111: op_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            3'b011: op_res = '0;
            default: op_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        overflow_d  = overflow_q;
        illegal_d   = illegal_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        acc_next    = mplier_q[0] ? acc_q + mcand_q : acc_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (alu_ctrl == 3'b011) begin
                        mcand_d     = src_a;
                        mplier_d    = src_b;
                        acc_d       = '0;
                        cnt_d       = '0;
                        out_valid_d = 1'b0;
                        state_d     = StMul;
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = op_res;
                        zero_d      = (op_res == '0);
                        overflow_d  = op_ovf;
                        illegal_d   = op_ill;
                    end
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                end
            end
            StMul: begin
                acc_d    = acc_next;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CntLast) begin
                    result_d   = acc_next;
                    zero_d     = (acc_next == '0);
                    overflow_d = 1'b0;
                    illegal_d  = 1'b0;
                    state_d    = StDone;
                end
            end
            StDone: begin
                // One extra cycle before presenting the product gives the WIDTH+1 latency
                if (!out_valid_q) begin
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            overflow_q  <= overflow_d;
            illegal_q   <= illegal_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule
